// File: rtl/ota_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : ota_decimator
//  Description : Single-bit comparator decimator. Synchronizes the raw OTA
//                comparator bit, counts 1-samples over a window of
//                2^WIN_LOG2 samples and presents each window count through
//                a valid/ready output register with a sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ota_decimator #(
    parameter int WIN_LOG2 = 8,
    parameter int OUT_W    = WIN_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             cmp_in,
    output logic [OUT_W-1:0] out_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             running
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_RUN    = 2'd2;

    localparam logic [WIN_LOG2-1:0] c_CNT_LAST = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] c_CNT_ONE  = {{(WIN_LOG2-1){1'b0}}, 1'b1};

    // Reset conditioning: asserts immediately with rst, releases two clocks
    // after rst falls so no flop sees reset removal near a clock edge.
    logic [1:0]          r_rst_pipe;
    logic                w_rst_int;

    // Comparator synchronizer; r_sync[1] is the only sample source.
    logic [1:0]          r_sync;
    logic                w_sample;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_settle_cnt;

    logic [WIN_LOG2-1:0] r_cnt;
    logic [OUT_W-1:0]    r_acc;
    logic [OUT_W-1:0]    w_result;
    logic                w_accum;
    logic                w_win_done;
    logic                w_take;

    logic [OUT_W-1:0]    r_out_code;
    logic                r_out_valid;
    logic                r_overrun;

    assign w_rst_int  = r_rst_pipe[1];
    assign w_sample   = r_sync[1];
    assign w_accum    = (r_state == c_ST_RUN) && ena;
    assign w_win_done = w_accum && (r_cnt == c_CNT_LAST);
    assign w_result   = r_acc + {{(OUT_W-1){1'b0}}, w_sample};
    assign w_take     = r_out_valid && out_ready;

    assign out_code  = r_out_code;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign running   = (r_state == c_ST_RUN);

    // Asynchronous-assert, synchronous-release internal reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_pipe <= 2'b11;
        end else begin
            r_rst_pipe <= {r_rst_pipe[0], 1'b0};
        end
    end

    // Two-flop synchronizer for the asynchronous comparator bit. A floating
    // pin resolves to an arbitrary level here; SETTLE flushes it on start.
    always_ff @(posedge clk or posedge w_rst_int) begin
        if (w_rst_int) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], cmp_in};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge w_rst_int) begin
        if (w_rst_int) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: ena low from any state returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (ena) begin
                    w_state_nxt = c_ST_SETTLE;
                end
            end
            c_ST_SETTLE: begin
                if (!ena) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_settle_cnt) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (!ena) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // SETTLE dwell counter: two cycles, wraps back to 0 on the exit edge.
    always_ff @(posedge clk or posedge w_rst_int) begin
        if (w_rst_int) begin
            r_settle_cnt <= 1'b0;
        end else if ((r_state == c_ST_SETTLE) && ena) begin
            r_settle_cnt <= ~r_settle_cnt;
        end else begin
            r_settle_cnt <= 1'b0;
        end
    end

    // Window accumulator and sample counter; cleared outside RUN and on the
    // last sample so the next window begins on the following cycle.
    always_ff @(posedge clk or posedge w_rst_int) begin
        if (w_rst_int) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accum && !w_win_done) begin
            r_acc <= w_result;
            r_cnt <= r_cnt + c_CNT_ONE;
        end else begin
            r_acc <= '0;
            r_cnt <= '0;
        end
    end

    // Output register, handshake and sticky overrun. A completed window
    // loads only if the slot is empty or being consumed on the same edge;
    // otherwise the new result is dropped and overrun latches.
    always_ff @(posedge clk or posedge w_rst_int) begin
        if (w_rst_int) begin
            r_out_code  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_win_done) begin
                if (!r_out_valid || out_ready) begin
                    r_out_code  <= w_result;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_take) begin
                r_out_valid <= 1'b0;
            end
            if ((r_state == c_ST_IDLE) && ena) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ota_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ota_decimator
//  Description : Directed self-checking bench for ota_decimator with
//                WIN_LOG2=3 (8-sample windows) and OUT_W=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ota_decimator;

    localparam int WIN_LOG2 = 3;
    localparam int OUT_W    = 4;

    logic             clk;
    logic             rst;
    logic             ena;
    logic             cmp_in;
    logic [OUT_W-1:0] out_code;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             running;

    int n_checks = 0;
    int n_errors = 0;

    ota_decimator #(
        .WIN_LOG2 (WIN_LOG2),
        .OUT_W    (OUT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .cmp_in    (cmp_in),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        ena       = 1'b0;
        cmp_in    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid",   out_valid, 0);
        check("rst_code",    out_code,  0);
        check("rst_overrun", overrun,   0);
        check("rst_running", running,   0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("idle_running", running, 0);

        // Constant 1 input, consumer always ready: first result 8 at edge 11.
        cmp_in    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ena = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e <= 2) check("ones_settle_running", running, 0);
            if (e == 3) check("ones_run_at_3", running, 1);
            if (e < 11) check("ones_no_early_valid", out_valid, 0);
        end
        check("ones_valid_11", out_valid, 1);
        check("ones_code_8",   out_code,  8);
        tick();
        check("ones_consumed", out_valid, 0);
        ena = 1'b0;
        tick();
        check("ones_stop_running", running, 0);

        // Constant 0, consumer stalled: second window dropped at edge 19.
        cmp_in    = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        ena = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (e == 11) begin
                check("zero_valid_11",   out_valid, 1);
                check("zero_code_11",    out_code,  0);
                check("zero_no_overrun", overrun,   0);
            end
            if (e > 11 && e < 19) check("zero_hold_valid", out_valid, 1);
        end
        check("zero_overrun_19", overrun,   1);
        check("zero_valid_19",   out_valid, 1);
        check("zero_code_19",    out_code,  0);
        ena = 1'b0;
        tick();
        check("pend_running",       running,   0);
        check("pend_survives_ena",  out_valid, 1);
        check("pend_overrun_stick", overrun,   1);
        out_ready = 1'b1;
        tick();
        check("pend_consumed", out_valid, 0);
        tick();
        check("ready_no_effect", out_valid, 0);
        check("overrun_in_idle", overrun,   1);

        // Window 1 zeros, window 2 ones; window 2 completes while the first
        // result is still pending and ready rises on that very edge.
        out_ready = 1'b0;
        ena = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (e == 1) check("overrun_clear_start", overrun, 0);
            if (e == 11) begin
                check("mix_valid_11", out_valid, 1);
                check("mix_code_11",  out_code,  0);
            end
            if (e == 15) check("mix_code_held", out_code, 0);
            cmp_in = (e >= 9);
            if (e == 18) out_ready = 1'b1;
        end
        check("mix_code_19",    out_code,  8);
        check("mix_valid_19",   out_valid, 1);
        check("mix_no_overrun", overrun,   0);
        tick();
        check("mix_consumed_20", out_valid, 0);
        ena = 1'b0;
        tick();

        // Alternating input: every window counts 4.
        out_ready = 1'b1;
        cmp_in    = 1'b1;
        ena       = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            tick();
            cmp_in = ~cmp_in;
            if (e == 11 || e == 19 || e == 27) begin
                check("tog_valid", out_valid, 1);
                check("tog_code",  out_code,  4);
            end
            if (e == 12 || e == 20) check("tog_drop", out_valid, 0);
        end
        ena = 1'b0;
        tick();

        // ena dropped mid-window: partial window discarded.
        cmp_in = 1'b1;
        ena    = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 4) check("abort_running_4", running, 1);
            if (e == 5) ena = 1'b0;
        end
        check("abort_running_off", running, 0);
        for (int i = 0; i < 10; i++) tick();
        check("abort_no_valid", out_valid, 0);
        ena       = 1'b1;
        out_ready = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e < 11) check("restart_no_early_valid", out_valid, 0);
        end
        check("restart_valid",   out_valid, 1);
        check("restart_code",    out_code,  8);
        check("restart_overrun", overrun,   0);

        // Pending result, overrun set and partial window in flight, then an
        // asynchronous reset pulse between clock edges.
        for (int e = 12; e <= 22; e++) tick();
        check("pre_rst_overrun", overrun,   1);
        check("pre_rst_valid",   out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid",   out_valid, 0);
        check("async_rst_code",    out_code,  0);
        check("async_rst_overrun", overrun,   0);
        check("async_rst_running", running,   0);
        ena = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_valid", out_valid, 0);
        out_ready = 1'b1;
        ena       = 1'b1;
        for (int e = 1; e <= 11; e++) tick();
        check("post_rst_valid_11", out_valid, 1);
        check("post_rst_code_11",  out_code,  8);
        ena = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
